// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an eight-digit
// seven-segment display. Digits are shown one at a time for SHOW_CYC
// cycles, optionally separated by GAP_CYC blanking cycles. The digit
// index (sel) and its segment pattern (seg) are registered together so
// that they always belong to the same digit.
module seg_scan_ctrl #(
    parameter int unsigned SHOW_CYC = 50000,
    parameter int unsigned GAP_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lead,
    output logic [2:0]  sel,
    output logic [7:0]  seg,
    output logic        scan_tick,
    output logic        frame_done
);

    // One shared phase counter covers both SHOW (up to 2^20-1 cycles)
    // and GAP (up to 2^16-1 cycles).
    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam bit HAS_GAP = (GAP_CYC != 0);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       sel_nxt;
    logic [7:0]       seg_nxt;
    logic             tick_nxt;
    logic             frame_nxt;
    logic             show_nxt;
    logic             advance;

    logic [31:0]      pend_data;
    logic [7:0]       pend_dp;
    logic [31:0]      disp_data;
    logic [7:0]       disp_dp;
    logic [31:0]      disp_data_nxt;
    logic [7:0]       disp_dp_nxt;
    logic [31:0]      cur_data;
    logic [7:0]       cur_dp;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    // Full segment pattern for digit k (0 = leftmost), including the
    // decimal point and leading-zero blanking. Digit 7 is never blanked
    // so an all-zero value still shows a single 0.
    function automatic logic [7:0] digit_seg(
        input logic [31:0] d,
        input logic [7:0]  dp,
        input logic [2:0]  k,
        input logic        bl
    );
        logic [2:0] idx;
        logic [3:0] nib;
        logic       all_zero;
        logic       blank;
        idx      = 3'd7 - k;
        nib      = d[{idx, 2'b00} +: 4];
        all_zero = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i <= 32'(k)) begin
                all_zero = all_zero & (d[28 - 4 * i +: 4] == 4'h0);
            end
        end
        blank = bl && (k != 3'd7) && all_zero;
        return {~dp[idx], (blank ? 7'h7F : hex7(nib))};
    endfunction

    // A load in the same cycle as a display refresh bypasses pending.
    always_comb begin
        cur_data = load ? data    : pend_data;
        cur_dp   = load ? dp_mask : pend_dp;
    end

    // Next-state, next-output and display-refresh decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sel_nxt       = sel;
        seg_nxt       = seg;
        tick_nxt      = 1'b0;
        frame_nxt     = 1'b0;
        show_nxt      = 1'b0;
        advance       = 1'b0;
        disp_data_nxt = disp_data;
        disp_dp_nxt   = disp_dp;

        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
            seg_nxt   = '1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt     = SHOW;
                    cnt_nxt       = '0;
                    sel_nxt       = '0;
                    disp_data_nxt = cur_data;
                    disp_dp_nxt   = cur_dp;
                    show_nxt      = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_nxt = '0;
                        if (HAS_GAP) begin
                            state_nxt = GAP;
                            seg_nxt   = '1;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = cnt + CNT_W'(1);
                        show_nxt = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                    seg_nxt   = '1;
                end
            endcase

            // Moving to the next digit; the 7->0 wrap also refreshes the
            // display registers so a frame is never torn.
            if (advance) begin
                state_nxt = SHOW;
                sel_nxt   = sel + 3'd1;
                tick_nxt  = 1'b1;
                show_nxt  = 1'b1;
                if (sel == 3'd7) begin
                    frame_nxt     = 1'b1;
                    disp_data_nxt = cur_data;
                    disp_dp_nxt   = cur_dp;
                end
            end
        end

        // seg is derived from the same next-cycle sel and display value
        // that are registered on this edge, keeping them in lockstep.
        if (show_nxt) begin
            seg_nxt = digit_seg(disp_data_nxt, disp_dp_nxt, sel_nxt, blank_lead);
        end
    end

    // State, phase counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            seg        <= '1;
            scan_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            seg        <= seg_nxt;
            scan_tick  <= tick_nxt;
            frame_done <= frame_nxt;
        end
    end

    // Pending registers capture every load, in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
        end else if (load) begin
            pend_data <= data;
            pend_dp   <= dp_mask;
        end
    end

    // Display registers, refreshed only on scan start and frame wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            disp_data <= disp_data_nxt;
            disp_dp   <= disp_dp_nxt;
        end
    end

endmodule
